// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and elaboration helpers for the memory port arbiter family.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Ceiling log2, used to validate select and counter widths at elaboration.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester/memory handshake bundle between the arbiter and its clients.
interface mem_port_arbiter_if #(
  parameter int N_REQ     = 4,
  parameter int SEL_WIDTH = 2
);
  logic [N_REQ-1:0]     req;
  logic [SEL_WIDTH-1:0] sel;
  logic [N_REQ-1:0]     gnt;
  logic                 mem_req;
  logic                 mem_ready;
  logic [N_REQ-1:0]     done;
  logic                 err;
  logic                 busy;

  modport master (
    input  req, mem_ready,
    output sel, gnt, mem_req, done, err, busy
  );

  modport slave (
    output req, mem_ready,
    input  sel, gnt, mem_req, done, err, busy
  );
endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin search: first set request after last_i, wrapping.
module rr_pick #(
  parameter int N_REQ     = 4,
  parameter int SEL_WIDTH = 2
) (
  input  logic [N_REQ-1:0]     req_i,
  input  logic [SEL_WIDTH-1:0] last_i,
  output logic [SEL_WIDTH-1:0] winner_o,
  output logic                 valid_o
);

  function automatic logic [SEL_WIDTH-1:0] wrapIdx(input logic [SEL_WIDTH-1:0] base, input int k);
    return SEL_WIDTH'((int'(base) + k) % N_REQ);
  endfunction

  // Walk from the farthest candidate to the nearest so the nearest set bit wins.
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (req_i[wrapIdx(last_i, k)]) begin
        winner_o = wrapIdx(last_i, k);
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner selection and single-outstanding memory handshake with timeout.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int SEL_WIDTH = 2,
  parameter int TIMEOUT   = 255,
  parameter int CNT_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.master arb_io
);

  if (SEL_WIDTH != ((clog2(N_REQ) < 1) ? 1 : clog2(N_REQ))) begin : gen_badSelWidth
    $error("mem_port_arbiter: SEL_WIDTH does not match N_REQ");
  end
  if (N_REQ < 2 || N_REQ > 16) begin : gen_badNReq
    $error("mem_port_arbiter: N_REQ out of range");
  end
  if (TIMEOUT < 1 || clog2(TIMEOUT + 1) > CNT_WIDTH) begin : gen_badTimeout
    $error("mem_port_arbiter: TIMEOUT does not fit CNT_WIDTH");
  end

  arb_state_e           state_q;
  logic [SEL_WIDTH-1:0] sel_q;
  logic [SEL_WIDTH-1:0] last_q;
  logic [N_REQ-1:0]     gnt_q;
  logic [N_REQ-1:0]     done_q;
  logic                 memReq_q;
  logic                 err_q;
  logic                 busy_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  logic [SEL_WIDTH-1:0] pickIdx;
  logic                 pickValid;

  rr_pick #(
    .N_REQ    (N_REQ),
    .SEL_WIDTH(SEL_WIDTH)
  ) u_rrPick (
    .req_i   (arb_io.req),
    .last_i  (last_q),
    .winner_o(pickIdx),
    .valid_o (pickValid)
  );

  // last_q resets to N_REQ-1 so requester 0 is the first candidate searched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      last_q   <= SEL_WIDTH'(N_REQ - 1);
      gnt_q    <= '0;
      done_q   <= '0;
      memReq_q <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      done_q <= '0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pickValid) begin
            sel_q    <= pickIdx;
            gnt_q    <= N_REQ'(1) << pickIdx;
            memReq_q <= 1'b1;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          // A ready arriving on the timeout cycle still counts as a clean completion.
          if (arb_io.mem_ready || cnt_q == CNT_WIDTH'(TIMEOUT - 1)) begin
            done_q   <= gnt_q;
            err_q    <= !arb_io.mem_ready;
            gnt_q    <= '0;
            memReq_q <= 1'b0;
            busy_q   <= 1'b0;
            last_q   <= sel_q;
            state_q  <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign arb_io.sel     = sel_q;
  assign arb_io.gnt     = gnt_q;
  assign arb_io.mem_req = memReq_q;
  assign arb_io.done    = done_q;
  assign arb_io.err     = err_q;
  assign arb_io.busy    = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a completion scoreboard (TIMEOUT=4).
module tb_mem_port_arbiter;

  typedef struct packed {
    logic [3:0] done;
    logic       err;
  } doneExp_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  doneExp_t expQ[$];

  mem_port_arbiter_if #(.N_REQ(4), .SEL_WIDTH(2)) arbIf();

  mem_port_arbiter #(
    .N_REQ    (4),
    .SEL_WIDTH(2),
    .TIMEOUT  (4),
    .CNT_WIDTH(3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb_io(arbIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [3:0] r, input logic ready);
    arbIf.req       = r;
    arbIf.mem_ready = ready;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] eSel, input logic [3:0] eGnt,
                             input logic eMemReq, input logic eBusy);
    logic [7:0] obs;
    logic [7:0] exp;
    obs = {arbIf.sel, arbIf.gnt, arbIf.mem_req, arbIf.busy};
    exp = {eSel, eGnt, eMemReq, eBusy};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: sel/gnt/mem_req/busy observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Full transaction: grant idx, wait cycles with mem_ready low, then ready for one cycle.
  task automatic doTxn(input string tag, input logic [3:0] r, input int idx, input int waits);
    doneExp_t e;
    applyStimulus(r, 1'b0);
    step();
    checkOutput({tag, "_grant"}, 2'(idx), 4'(1) << idx, 1'b1, 1'b1);
    e.done = 4'(1) << idx;
    e.err  = 1'b0;
    expQ.push_back(e);
    repeat (waits) step();
    applyStimulus(4'b0000, 1'b1);
    step();
    checkOutput({tag, "_done"}, 2'(idx), 4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(4'b0000, 1'b0);
    step();
    checkOutput("reset", 2'd0, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Every done/err pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (arbIf.done !== 4'b0000 || arbIf.err !== 1'b0) begin
      vectors++;
      assert (expQ.size() != 0) else begin
        miscompares++;
        $error("[TB] FAIL spurious_done: observed done=%b err=%b expected no pulse", arbIf.done, arbIf.err);
      end
      if (expQ.size() != 0) begin
        doneExp_t e;
        e = expQ.pop_front();
        vectors++;
        assert ({arbIf.done, arbIf.err} === {e.done, e.err}) else begin
          miscompares++;
          $error("[TB] FAIL done_pulse: observed done=%b err=%b expected done=%b err=%b",
                 arbIf.done, arbIf.err, e.done, e.err);
        end
      end
    end
  end

  initial begin
    doneExp_t e;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    applyStimulus(4'b0000, 1'b0);
    #2;
    checkOutput("async_reset", 2'd0, 4'b0000, 1'b0, 1'b0);
    doReset();

    step();
    checkOutput("idle_no_req", 2'd0, 4'b0000, 1'b0, 1'b0);

    // Single requester, ready two cycles after mem_req rises.
    doTxn("single", 4'b0001, 0, 2);
    step();
    checkOutput("after_single", 2'd0, 4'b0000, 1'b0, 1'b0);

    // All requesting, memory answers on the second BUSY cycle: 3-cycle period.
    doReset();
    applyStimulus(4'b1111, 1'b0);
    step();
    for (int k = 0; k < 5; k++) begin
      checkOutput("rr_grant", 2'(k % 4), 4'(1) << (k % 4), 1'b1, 1'b1);
      e.done = 4'(1) << (k % 4);
      e.err  = 1'b0;
      expQ.push_back(e);
      step();
      applyStimulus((k == 4) ? 4'b0000 : 4'b1111, 1'b1);
      step();
      checkOutput("rr_done", 2'(k % 4), 4'b0000, 1'b0, 1'b0);
      applyStimulus((k == 4) ? 4'b0000 : 4'b1111, 1'b0);
      step();
    end
    checkOutput("rr_idle", 2'd0, 4'b0000, 1'b0, 1'b0);

    // Wrap-around: last=1 with req 0011 goes back to 0.
    doTxn("to1", 4'b0010, 1, 0);
    doTxn("wrap", 4'b0011, 0, 0);
    doTxn("then1", 4'b0010, 1, 0);

    // Timeout: owner drops req, memory never answers.
    applyStimulus(4'b0100, 1'b0);
    step();
    checkOutput("to_grant", 2'd2, 4'b0100, 1'b1, 1'b1);
    e.done = 4'b0100;
    e.err  = 1'b1;
    expQ.push_back(e);
    applyStimulus(4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("to_wait", 2'd2, 4'b0100, 1'b1, 1'b1);
    end
    step();
    checkOutput("to_abort", 2'd2, 4'b0000, 1'b0, 1'b0);

    // Ready on the final counter value is a normal completion.
    doTxn("ready_at_limit", 4'b1000, 3, 3);

    // Owner drops req mid-BUSY while requester 2 rises.
    applyStimulus(4'b0001, 1'b0);
    step();
    checkOutput("drop_grant", 2'd0, 4'b0001, 1'b1, 1'b1);
    e.done = 4'b0001;
    e.err  = 1'b0;
    expQ.push_back(e);
    step();
    applyStimulus(4'b0100, 1'b0);
    step();
    checkOutput("drop_frozen", 2'd0, 4'b0001, 1'b1, 1'b1);
    applyStimulus(4'b0100, 1'b1);
    step();
    checkOutput("drop_done", 2'd0, 4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b0100, 1'b0);
    step();
    checkOutput("drop_next", 2'd2, 4'b0100, 1'b1, 1'b1);
    e.done = 4'b0100;
    expQ.push_back(e);
    applyStimulus(4'b0000, 1'b1);
    step();
    applyStimulus(4'b0000, 1'b0);

    // Asynchronous reset mid-BUSY, then pointer restart.
    applyStimulus(4'b0010, 1'b0);
    step();
    checkOutput("pre_reset_grant", 2'd1, 4'b0010, 1'b1, 1'b1);
    step();
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_busy_reset", 2'd0, 4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b1000, 1'b0);
    #2;
    rst_n = 1'b1;
    doTxn("post_reset", 4'b1000, 3, 0);
    step();
    step();

    vectors++;
    assert (expQ.size() == 0) else begin
      miscompares++;
      $error("[TB] FAIL missing_done: observed %0d outstanding expected 0", expQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
